bist_tpg: RTL and testbench
===========================

BIST_TPG -- requirements
Module: bist_tpg

Interface
REQ-001 Parameter SEED, default 8'hB7, LFSR start state; a value of 0 SHALL be replaced by 8'h01.
REQ-002 Parameter N_PATTERNS, default 255, number of patterns per run, legal range 1..255.
REQ-003 Parameter GOLDEN, default 8'h00, expected signature.
REQ-004 CLK  in  1  sole clock, rising edge.
REQ-005 RST  in  1  reset, asynchronous, active-low.
REQ-006 bist_start  in  1  single-cycle request to begin a run.
REQ-007 sig  in  8  signature from the response compactor, MSB = h0.
REQ-008 pattern  out  8  test vector to the circuit under test.
REQ-009 pattern_valid  out  1  high exactly on cycles where pattern is a counted test vector.
REQ-010 bist_end  out  1  freezes the compactor; low in IDLE and RUN, high in DRAIN and DONE.
REQ-011 busy  out  1  high in RUN and DRAIN.
REQ-012 done  out  1  high in DONE.
REQ-013 pass  out  1  compare result; valid only while done=1, otherwise 0.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-015 IDLE or DONE with bist_start=1 -> RUN on the next edge; pattern=SEED, count=1, pass=0, done=0.
REQ-016 In RUN, every cycle SHALL have pattern_valid=1; the LFSR advances each edge, next = {p[6:0], p[7]^p[5]^p[4]^p[3]}, which gives period 255.
REQ-017 When RUN reaches count == N_PATTERNS, it SHALL go to DRAIN on the next edge; pattern_valid was high for exactly N_PATTERNS cycles.
REQ-018 DRAIN SHALL last exactly 2 cycles, covering the compactor's one-cycle output register lag, with bist_end=1 and pattern_valid=0.
REQ-019 On leaving DRAIN, the block SHALL sample sig, set pass = (sig == GOLDEN), and enter DONE.
REQ-020 DONE SHALL hold done=1, pass, and bist_end=1 until bist_start or reset.
REQ-021 bist_start SHALL be ignored in RUN and DRAIN.
REQ-022 In IDLE and DONE, pattern SHALL hold its last value and pattern_valid=0.
REQ-023 N_PATTERNS=1 SHALL give exactly one valid cycle with pattern=SEED, then DRAIN.
REQ-024 The LFSR SHALL never enter state 0; the SEED substitution in REQ-001 guarantees this.
REQ-025 The pattern counter SHALL be 8 bits and SHALL never wrap within a run.

Reset
REQ-026 RST=0 SHALL, immediately and asynchronously, set state=IDLE, pattern=SEED, count=0, pattern_valid=0, bist_end=0, busy=0, done=0, pass=0.
REQ-027 Reset during RUN or DRAIN SHALL abort the run with no done pulse; a new run needs bist_start after RST returns to 1.
REQ-028 Release of reset SHALL take effect on the first CLK edge after RST returns to 1.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding, the LFSR width (8), and the tap mask 8'hB8.
REQ-030 The LFSR SHALL be a separate sub-module lfsr8 with ports CLK, RST, load, seed[7:0], en, q[7:0]; the FSM and counter SHALL live in bist_tpg.

Verification
REQ-031 SEED=8'h01, N_PATTERNS=5, pulse bist_start -> pattern 01,02,04,08,11 with pattern_valid high 5 cycles, then bist_end=1 for 2 cycles, then done=1.
REQ-032 SEED=8'h01, N_PATTERNS=255, sig tied to 8'h00, GOLDEN=8'h00 -> 255 distinct nonzero patterns, pass=1, done=1.
REQ-033 GOLDEN=8'h5A with sig=8'h5B in DRAIN -> done=1, pass=0.
REQ-034 Pulse bist_start at the 3rd RUN cycle -> it is ignored and the valid-cycle count is still N_PATTERNS.
REQ-035 RST=0 mid-RUN, asynchronous to CLK -> outputs take reset values before the next edge; a later bist_start restarts from SEED.
REQ-036 SEED=8'h00 -> first pattern 8'h01 and the LFSR never reaches 00.

Source files
------------

// File: rtl/bist_tpg_pkg.sv
// Shared definitions for the BIST pattern generator: FSM encoding, LFSR width/taps
// and the LFSR step function used by lfsr8.
package bist_tpg_pkg;

   localparam int LFSR_W = 8;
   localparam logic [LFSR_W-1:0] TAP_MASK = 8'hB8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Fibonacci step: shift left, feedback is the parity of the tapped bits 7,5,4,3.
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] p);
      return {p[LFSR_W-2:0], ^(p & TAP_MASK)};
   endfunction

endpackage

// File: rtl/bist_tpg_lfsr8.sv
// 8-bit maximal-length LFSR with synchronous seed load; q updates one edge after load/en.
// No flow control: advances on every edge with en high.
module lfsr8
   import bist_tpg_pkg::*;
#(
   parameter logic [LFSR_W-1:0] INIT = 8'h01
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              load,
   input  logic [LFSR_W-1:0] seed,
   input  logic              en,
   output logic [LFSR_W-1:0] q
);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         q <= INIT;
      end else if (load) begin
         q <= seed;
      end else if (en) begin
         q <= lfsr_next(q);
      end
   end

endmodule

// File: rtl/bist_tpg.sv
// BIST test-pattern generator: runs N_PATTERNS LFSR vectors, drains 2 cycles, then grades sig.
// Pattern appears the edge after bist_start; bist_start is ignored while busy.
module bist_tpg
   import bist_tpg_pkg::*;
#(
   parameter logic [7:0] SEED       = 8'hB7,
   parameter int         N_PATTERNS = 255,
   parameter logic [7:0] GOLDEN     = 8'h00
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       bist_start,
   input  logic [7:0] sig,
   output logic [7:0] pattern,
   output logic       pattern_valid,
   output logic       bist_end,
   output logic       busy,
   output logic       done,
   output logic       pass
);

   // An all-zero seed would lock the LFSR, so it is promoted to 01.
   localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
   localparam logic [7:0] N_LAST   = 8'(N_PATTERNS);

   state_t     state, state_nxt;
   logic [7:0] count;
   logic       drain_cnt;
   logic       pass_q;
   logic       start_run;
   logic       lfsr_en;

   lfsr8 #(.INIT(SEED_EFF)) u_lfsr (
      .CLK  (CLK),
      .RST  (RST),
      .load (start_run),
      .seed (SEED_EFF),
      .en   (lfsr_en),
      .q    (pattern)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      start_run     = 1'b0;
      lfsr_en       = 1'b0;
      pattern_valid = 1'b0;
      bist_end      = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bist_start) begin
               state_nxt = ST_RUN;
               start_run = 1'b1;
            end
         end
         ST_RUN: begin
            pattern_valid = 1'b1;
            busy          = 1'b1;
            // Hold the LFSR on the final vector so pattern keeps the last value afterwards.
            lfsr_en       = (count != N_LAST);
            if (count == N_LAST) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            bist_end = 1'b1;
            busy     = 1'b1;
            if (drain_cnt) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            bist_end = 1'b1;
            done     = 1'b1;
            if (bist_start) begin
               state_nxt = ST_RUN;
               start_run = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      pass = done & pass_q;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         count     <= 8'd0;
         drain_cnt <= 1'b0;
         pass_q    <= 1'b0;
      end else begin
         if (start_run) begin
            count <= 8'd1;
         end else if (lfsr_en) begin
            count <= count + 8'd1;
         end
         drain_cnt <= (state == ST_DRAIN) && !drain_cnt;
         // Compactor output has settled by the second drain cycle.
         if (start_run) begin
            pass_q <= 1'b0;
         end else if ((state == ST_DRAIN) && drain_cnt) begin
            pass_q <= (sig == GOLDEN);
         end
      end
   end

endmodule

// File: tb/tb_bist_tpg.sv
// Scoreboard bench for bist_tpg: four instances cover short runs, full period, zero seed and N=1.
module tb_bist_tpg;

   logic CLK = 1'b0;
   logic RST;
   logic start_a, start_b;
   logic [7:0] sig_a, sig_b, sig_c, sig_d;

   logic [7:0] pat_a, pat_b, pat_c, pat_d;
   logic pv_a, pv_b, pv_c, pv_d;
   logic end_a, end_b, end_c, end_d;
   logic busy_a, busy_b, busy_c, busy_d;
   logic done_a, done_b, done_c, done_d;
   logic pass_a, pass_b, pass_c, pass_d;

   always #5 CLK = ~CLK;

   bist_tpg #(.SEED(8'h01), .N_PATTERNS(5), .GOLDEN(8'h5A)) dut_a (
      .CLK(CLK), .RST(RST), .bist_start(start_a), .sig(sig_a), .pattern(pat_a),
      .pattern_valid(pv_a), .bist_end(end_a), .busy(busy_a), .done(done_a), .pass(pass_a));

   bist_tpg #(.SEED(8'h01), .N_PATTERNS(255), .GOLDEN(8'h00)) dut_b (
      .CLK(CLK), .RST(RST), .bist_start(start_b), .sig(sig_b), .pattern(pat_b),
      .pattern_valid(pv_b), .bist_end(end_b), .busy(busy_b), .done(done_b), .pass(pass_b));

   bist_tpg #(.SEED(8'h00), .N_PATTERNS(255), .GOLDEN(8'h5A)) dut_c (
      .CLK(CLK), .RST(RST), .bist_start(start_b), .sig(sig_c), .pattern(pat_c),
      .pattern_valid(pv_c), .bist_end(end_c), .busy(busy_c), .done(done_c), .pass(pass_c));

   bist_tpg #(.N_PATTERNS(1)) dut_d (
      .CLK(CLK), .RST(RST), .bist_start(start_b), .sig(sig_d), .pattern(pat_d),
      .pattern_valid(pv_d), .bist_end(end_d), .busy(busy_d), .done(done_d), .pass(pass_d));

   int tests = 0;
   int fails = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h", tag, got, want);
      end
   endtask

   function automatic logic [7:0] model_next(input logic [7:0] p);
      return {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
   endfunction

   logic [7:0] q_a[$], q_b[$], q_c[$], q_d[$];
   int vcnt_a, dcnt_a, vcnt_b, vcnt_c, vcnt_d, zero_c;
   bit seen_b[256];

   always @(negedge CLK) begin
      if (pv_a) begin
         vcnt_a++;
         if (q_a.size() == 0) check_eq("a_unexpected_valid", 32'd1, 32'd0);
         else check_eq("a_pattern", pat_a, q_a.pop_front());
      end
      if (busy_a && end_a) dcnt_a++;
      if (pv_b) begin
         vcnt_b++;
         seen_b[pat_b] = 1'b1;
         if (q_b.size() == 0) check_eq("b_unexpected_valid", 32'd1, 32'd0);
         else check_eq("b_pattern", pat_b, q_b.pop_front());
      end
      if (pv_c) begin
         vcnt_c++;
         if (pat_c == 8'h00) zero_c++;
         if (q_c.size() == 0) check_eq("c_unexpected_valid", 32'd1, 32'd0);
         else check_eq("c_pattern", pat_c, q_c.pop_front());
      end
      if (pv_d) begin
         vcnt_d++;
         if (q_d.size() == 0) check_eq("d_unexpected_valid", 32'd1, 32'd0);
         else check_eq("d_pattern", pat_d, q_d.pop_front());
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic push_a();
      logic [7:0] exp_a [5];
      exp_a = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
      for (int i = 0; i < 5; i++) q_a.push_back(exp_a[i]);
      vcnt_a = 0;
      dcnt_a = 0;
   endtask

   task automatic wait_done_a(input int budget);
      int k = 0;
      while (!done_a && k < budget) begin
         tick(1);
         k++;
      end
      check_eq("a_done_reached", done_a, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] p;
      int k;
      int distinct;
      RST = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      sig_a = 8'h00; sig_b = 8'h00; sig_c = 8'h00; sig_d = 8'h00;
      #2 RST = 1'b0;
      #1;
      check_eq("rst_pat_a", pat_a, 8'h01);
      check_eq("rst_pat_c_zero_seed", pat_c, 8'h01);
      check_eq("rst_pat_d", pat_d, 8'hB7);
      check_eq("rst_outputs_a", {pv_a, end_a, busy_a, done_a, pass_a}, 5'b0);
      tick(2);
      RST = 1'b1;
      tick(2);
      check_eq("idle_after_release", {pv_a, busy_a, done_a, end_a}, 4'b0);

      // Run 1: signature mismatch
      sig_a = 8'h5B;
      push_a();
      start_a = 1'b1; tick(1); start_a = 1'b0;
      wait_done_a(20);
      check_eq("a1_valid_cycles", vcnt_a, 5);
      check_eq("a1_drain_cycles", dcnt_a, 2);
      check_eq("a1_queue_empty", q_a.size(), 0);
      check_eq("a1_done_flags", {done_a, end_a, busy_a, pv_a}, 4'b1100);
      check_eq("a1_pass", pass_a, 1'b0);

      // Run 2: restart from DONE, matching signature, stray start in 3rd RUN cycle
      sig_a = 8'h5A;
      push_a();
      start_a = 1'b1; tick(1); start_a = 1'b0;
      tick(2);
      start_a = 1'b1; tick(1); start_a = 1'b0;
      wait_done_a(20);
      check_eq("a2_valid_cycles", vcnt_a, 5);
      check_eq("a2_queue_empty", q_a.size(), 0);
      check_eq("a2_pass", pass_a, 1'b1);
      tick(3);
      check_eq("a2_done_held", {done_a, pass_a, end_a}, 3'b111);

      // Concurrent runs: full period, zero seed with mismatch, single pattern
      sig_b = 8'h00; sig_c = 8'h5B; sig_d = 8'h00;
      p = 8'h01;
      for (int i = 0; i < 255; i++) begin
         q_b.push_back(p);
         q_c.push_back(p);
         p = model_next(p);
      end
      q_d.push_back(8'hB7);
      vcnt_b = 0; vcnt_c = 0; vcnt_d = 0; zero_c = 0;
      for (int i = 0; i < 256; i++) seen_b[i] = 1'b0;
      start_b = 1'b1; tick(1); start_b = 1'b0;
      k = 0;
      while (!(done_b && done_c && done_d) && k < 400) begin
         tick(1);
         k++;
      end
      check_eq("bcd_done_reached", {done_b, done_c, done_d}, 3'b111);
      distinct = 0;
      for (int i = 0; i < 256; i++) if (seen_b[i]) distinct++;
      check_eq("b_valid_cycles", vcnt_b, 255);
      check_eq("b_distinct", distinct, 255);
      check_eq("b_zero_never_seen", seen_b[0], 1'b0);
      check_eq("b_pass", pass_b, 1'b1);
      check_eq("c_valid_cycles", vcnt_c, 255);
      check_eq("c_no_zero_state", zero_c, 0);
      check_eq("c_pass", pass_c, 1'b0);
      check_eq("d_valid_cycles", vcnt_d, 1);
      check_eq("d_pass", pass_d, 1'b1);
      check_eq("bcd_queues_empty", q_b.size() + q_c.size() + q_d.size(), 0);

      // Asynchronous reset in the middle of a run
      push_a();
      start_a = 1'b1; tick(1); start_a = 1'b0;
      tick(2);
      #2 RST = 1'b0;
      #1;
      check_eq("abort_outputs", {pv_a, end_a, busy_a, done_a, pass_a}, 5'b0);
      check_eq("abort_pattern", pat_a, 8'h01);
      q_a.delete();
      tick(2);
      RST = 1'b1;
      tick(3);
      check_eq("abort_stays_idle", {busy_a, done_a, pv_a}, 3'b0);
      push_a();
      start_a = 1'b1; tick(1); start_a = 1'b0;
      wait_done_a(20);
      check_eq("a3_valid_cycles", vcnt_a, 5);
      check_eq("a3_queue_empty", q_a.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
